// File: rtl/bus_map_pkg.sv
// ============================================================================
// Module : bus_map_pkg
// Brief  : Shared address-map constants and region type for memory_bus_target.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_map_pkg;

    localparam logic [3:0] IO_PORT_OUT = 4'h0;
    localparam logic [3:0] IO_PORT_IN  = 4'h1;
    localparam logic [3:0] IO_RELOAD   = 4'h2;
    localparam logic [3:0] IO_COUNT    = 4'h3;
    localparam logic [3:0] IO_CTRL     = 4'h4;
    localparam logic [3:0] IO_STATUS   = 4'h5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [15:0] VEC_NMI_ADDR   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR   = 16'hFFFE;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_VEC  = 2'd2,
        REGION_NONE = 2'd3
    } region_t;

endpackage

`default_nettype wire

// File: rtl/interval_timer.sv
// ============================================================================
// Module : interval_timer
// Brief  : Prescaled 8-bit down-counter with reload, auto-reload and IRQ flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interval_timer
    import bus_map_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_reload,
    input  logic       wr_ctrl,
    input  logic       wr_status,
    input  logic [7:0] wdata,
    output logic [7:0] reload,
    output logic [7:0] count,
    output logic [2:0] ctrl,
    output logic       expired,
    output logic       irq
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          expire_now;

    assign tick       = ctrl[CTRL_EN] && (presc == PRE_MAX);
    assign expire_now = tick && (count == 8'h00);
    assign irq        = expired & ctrl[CTRL_IRQ_EN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (wr_reload || !ctrl[CTRL_EN] || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload <= 8'h00;
            count  <= 8'h00;
        end else begin
            if (wr_reload) begin
                reload <= wdata;
            end
            // A RELOAD write takes precedence over a tick on the same edge
            if (wr_reload) begin
                count <= wdata;
            end else if (tick) begin
                if (count != 8'h00) begin
                    count <= count - 8'h01;
                end else if (ctrl[CTRL_AUTO]) begin
                    count <= reload;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl    <= 3'b000;
            expired <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata[2:0];
            end
            // One-shot expiry clears enable even against a concurrent CTRL write
            if (expire_now && !ctrl[CTRL_AUTO]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end
            if (expire_now) begin
                expired <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                expired <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_bus_target.sv
// ============================================================================
// Module : memory_bus_target
// Brief  : CPU bus responder: RAM, I/O page (ports, timer), optional vectors
//          enabled by MEMORY_BUS_TARGET_VECTORS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_bus_target
    import bus_map_pkg::*;
#(
    parameter int          RAM_AW    = 11,
    parameter logic [7:0]  IO_PAGE   = 8'hFE,
    parameter int          PRESCALE  = 16,
`ifdef MEMORY_BUS_TARGET_VECTORS_EN
    parameter logic [15:0] NMI_VEC   = 16'h0000,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300,
`endif
    parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic        timer_irq
);

    localparam logic [16:0] RAM_SIZE = 17'd1 << RAM_AW;

    logic [7:0]  mem [RAM_SIZE];
    region_t     region;
    logic [3:0]  offset;
    logic        io_wr;
    logic [7:0]  sync_1;
    logic [7:0]  sync_2;
    logic [7:0]  t_reload;
    logic [7:0]  t_count;
    logic [2:0]  t_ctrl;
    logic        t_expired;

    assign offset = address[3:0];

    always_comb begin
        region = REGION_NONE;
        if ({1'b0, address} < RAM_SIZE) begin
            region = REGION_RAM;
        end else if (address[15:8] == IO_PAGE && address[7:4] == 4'h0) begin
            region = REGION_IO;
`ifdef MEMORY_BUS_TARGET_VECTORS_EN
        end else if (address >= VEC_NMI_ADDR) begin
            region = REGION_VEC;
`endif
        end
    end

    assign io_wr = !read_write && (region == REGION_IO);

    always_ff @(posedge clk) begin
        if (!read_write && region == REGION_RAM) begin
            mem[address[RAM_AW-1:0]] <= data_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_out <= 8'h00;
            sync_1   <= 8'h00;
            sync_2   <= 8'h00;
        end else begin
            if (io_wr && offset == IO_PORT_OUT) begin
                port_out <= data_write;
            end
            sync_1 <= port_in;
            sync_2 <= sync_1;
        end
    end

    interval_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .wr_reload (io_wr && offset == IO_RELOAD),
        .wr_ctrl   (io_wr && offset == IO_CTRL),
        .wr_status (io_wr && offset == IO_STATUS),
        .wdata     (data_write),
        .reload    (t_reload),
        .count     (t_count),
        .ctrl      (t_ctrl),
        .expired   (t_expired),
        .irq       (timer_irq)
    );

    always_comb begin
        data_read = OPEN_BUS;
        case (region)
            REGION_RAM: data_read = mem[address[RAM_AW-1:0]];
            REGION_IO: begin
                case (offset)
                    IO_PORT_OUT: data_read = port_out;
                    IO_PORT_IN:  data_read = sync_2;
                    IO_RELOAD:   data_read = t_reload;
                    IO_COUNT:    data_read = t_count;
                    IO_CTRL:     data_read = {5'b00000, t_ctrl};
                    IO_STATUS:   data_read = {7'b0000000, t_expired};
                    default:     data_read = 8'h00;
                endcase
            end
`ifdef MEMORY_BUS_TARGET_VECTORS_EN
            REGION_VEC: begin
                case (address[2:0])
                    VEC_NMI_ADDR[2:0]:          data_read = NMI_VEC[7:0];
                    VEC_NMI_ADDR[2:0] + 3'd1:   data_read = NMI_VEC[15:8];
                    VEC_RESET_ADDR[2:0]:        data_read = RESET_VEC[7:0];
                    VEC_RESET_ADDR[2:0] + 3'd1: data_read = RESET_VEC[15:8];
                    VEC_IRQ_ADDR[2:0]:          data_read = IRQ_VEC[7:0];
                    VEC_IRQ_ADDR[2:0] + 3'd1:   data_read = IRQ_VEC[15:8];
                    default:                    data_read = OPEN_BUS;
                endcase
            end
`endif
            default: data_read = OPEN_BUS;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_bus_target.sv
// ============================================================================
// Module : tb_memory_bus_target
// Brief  : Directed self-checking bench for memory_bus_target.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_bus_target;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic        timer_irq;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];

    memory_bus_target dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_read  (data_read),
        .port_in    (port_in),
        .port_out   (port_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic sample_check(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        #1;
        check8(tag, data_read, exp_q.pop_front());
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        address    = addr;
        read_write = 1'b1;
        sample_check(tag, exp);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        address    = addr;
        data_write = data;
        read_write = 1'b0;
        @(posedge clk);
        #1;
        read_write = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        address    = 16'h0000;
        read_write = 1'b1;
        data_write = 8'h00;
        port_in    = 8'h00;
        cycles(2);

        // Reset state
        check8("rst_port_out", port_out, 8'h00);
        check8("rst_irq", {7'b0, timer_irq}, 8'h00);
        read_check("rst_count", 16'hFE03, 8'h00);
        read_check("rst_ctrl", 16'hFE04, 8'h00);
        read_check("rst_status", 16'hFE05, 8'h00);
        read_check("rst_reload", 16'hFE02, 8'h00);
        rst = 1'b1;
        cycles(1);

        // RAM
        bus_write(16'h0010, 8'hA5);
        read_check("ram_0010", 16'h0010, 8'hA5);
        bus_write(16'h07FF, 8'h3C);
        read_check("ram_07ff", 16'h07FF, 8'h3C);
        read_check("ram_0800_open", 16'h0800, 8'hFF);
        bus_write(16'h0800, 8'h11);
        read_check("ram_0800_wr_ignored", 16'h0800, 8'hFF);
        read_check("ram_0000_untouched", 16'h0000 + 16'h0010, 8'hA5);
        address    = 16'h0010;
        data_write = 8'h77;
        read_write = 1'b0;
        sample_check("ram_rdw_old", 8'hA5);
        @(posedge clk);
        #1;
        sample_check("ram_rdw_new", 8'h77);
        read_write = 1'b1;

        // I/O page decode edges
        read_check("io_unused_06", 16'hFE06, 8'h00);
        read_check("io_page_hi_open", 16'hFE10, 8'hFF);

        // Ports
        bus_write(16'hFE00, 8'h5A);
        check8("port_out_5a", port_out, 8'h5A);
        read_check("port_out_rb", 16'hFE00, 8'h5A);
        bus_write(16'hFE01, 8'h99);
        read_check("port_in_wr_ignored", 16'hFE01, 8'h00);
        port_in = 8'hC3;
        read_check("port_in_old0", 16'hFE01, 8'h00);
        cycles(1);
        read_check("port_in_old1", 16'hFE01, 8'h00);
        cycles(1);
        read_check("port_in_new", 16'hFE01, 8'hC3);

        // One-shot timer
        bus_write(16'hFE02, 8'h03);
        bus_write(16'hFE04, 8'h05);
        read_check("os_count_e0", 16'hFE03, 8'h03);
        cycles(15);
        read_check("os_count_e15", 16'hFE03, 8'h03);
        cycles(1);
        read_check("os_count_e16", 16'hFE03, 8'h02);
        cycles(16);
        read_check("os_count_e32", 16'hFE03, 8'h01);
        cycles(16);
        read_check("os_count_e48", 16'hFE03, 8'h00);
        cycles(15);
        read_check("os_status_e63", 16'hFE05, 8'h00);
        check8("os_irq_e63", {7'b0, timer_irq}, 8'h00);
        cycles(1);
        read_check("os_status_e64", 16'hFE05, 8'h01);
        check8("os_irq_e64", {7'b0, timer_irq}, 8'h01);
        read_check("os_ctrl_e64", 16'hFE04, 8'h04);
        cycles(20);
        read_check("os_count_stays0", 16'hFE03, 8'h00);

        // Auto-reload
        bus_write(16'hFE05, 8'h01);
        check8("ar_irq_cleared", {7'b0, timer_irq}, 8'h00);
        bus_write(16'hFE02, 8'h02);
        bus_write(16'hFE04, 8'h07);
        cycles(47);
        read_check("ar_status_e47", 16'hFE05, 8'h00);
        cycles(1);
        read_check("ar_status_e48", 16'hFE05, 8'h01);
        check8("ar_irq_e48", {7'b0, timer_irq}, 8'h01);
        read_check("ar_count_reload", 16'hFE03, 8'h02);
        read_check("ar_ctrl_kept", 16'hFE04, 8'h07);
        bus_write(16'hFE05, 8'h01);
        check8("ar_w1c_irq", {7'b0, timer_irq}, 8'h00);
        read_check("ar_w1c_status", 16'hFE05, 8'h00);
        cycles(46);
        read_check("ar_status_e95", 16'hFE05, 8'h00);
        bus_write(16'hFE05, 8'h01);
        read_check("ar_set_wins", 16'hFE05, 8'h01);
        check8("ar_set_wins_irq", {7'b0, timer_irq}, 8'h01);

        // Asynchronous reset mid-count
        check8("pre_rst_port_out", port_out, 8'h5A);
        #2;
        rst = 1'b0;
        #1;
        check8("arst_port_out", port_out, 8'h00);
        check8("arst_irq", {7'b0, timer_irq}, 8'h00);
        read_check("arst_count", 16'hFE03, 8'h00);
        cycles(1);
        rst = 1'b1;
        cycles(1);

        // Vector region
`ifdef MEMORY_BUS_TARGET_VECTORS_EN
        read_check("vec_fffc", 16'hFFFC, 8'h00);
        read_check("vec_fffd", 16'hFFFD, 8'h02);
        read_check("vec_ffff", 16'hFFFF, 8'h03);
        bus_write(16'hFFFC, 8'h55);
        read_check("vec_wr_ignored", 16'hFFFC, 8'h00);
        read_check("vec_fff9_open", 16'hFFF9, 8'hFF);
`else
        read_check("novec_fffc", 16'hFFFC, 8'hFF);
        read_check("novec_fffd", 16'hFFFD, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
